// File: rtl/ansi_decoder.sv
// ansi_decoder
//   Turns a raw terminal byte stream into a stream of decoded commands
//   (printable character, newline, cursor goto/home, clear screen, SGR).
//   One byte is consumed per input transfer; a command appears one cycle
//   after the byte that completes it and is held until the consumer takes it.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready
//   are both high; the producer holds its payload stable while valid is high
//   and ready is low. in_ready is high whenever no command is pending or the
//   pending command is being accepted in the same cycle.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   input byte handshake, in_data = byte
//   cmd_valid/cmd_ready command handshake
//   cmd_op              0 CHAR, 1 NEWLINE, 2 GOTO, 3 SGR, 4 CLEAR, 5 HOME
//   cmd_char            byte for CHAR, 0 otherwise
//   cmd_arg0/cmd_arg1   GOTO row/column or SGR arguments
//   cmd_nargs           SGR argument count (0-2)
//   err_count           saturating count of malformed/dropped sequences
//   o_dbg_state         current FSM state (0 IDLE, 1 ESC, 2 CSI)
//
// Build option: define ANSI_DECODER_ERRCNT_EN to enable the error counter;
//   without it err_count is tied to 0.
module ansi_decoder #(
  parameter int ARG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [2:0]       cmd_op,
  output logic [7:0]       cmd_char,
  output logic [ARG_W-1:0] cmd_arg0,
  output logic [ARG_W-1:0] cmd_arg1,
  output logic [1:0]       cmd_nargs,
  output logic [7:0]       err_count,
  output logic [1:0]       o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ESC  = 2'd1,
    S_CSI  = 2'd2
  } state_t;

  localparam logic [2:0] OP_CHAR    = 3'd0;
  localparam logic [2:0] OP_NEWLINE = 3'd1;
  localparam logic [2:0] OP_GOTO    = 3'd2;
  localparam logic [2:0] OP_SGR     = 3'd3;
  localparam logic [2:0] OP_CLEAR   = 3'd4;
  localparam logic [2:0] OP_HOME    = 3'd5;

  localparam logic [ARG_W-1:0] ARG_MAX = '1;
  localparam logic [ARG_W-1:0] ARG_ONE = ARG_W'(1);
  localparam logic [ARG_W-1:0] ARG_TWO = ARG_W'(2);

  // arg*10 + digit, clamped to the largest representable argument.
  // Four extra bits are enough to hold 10*max + 9 without wrapping.
  function automatic logic [ARG_W-1:0] acc_digit(input logic [ARG_W-1:0] a,
                                                 input logic [3:0] d);
    logic [ARG_W+3:0] w_sum;
    w_sum = ({4'b0, a} << 3) + ({4'b0, a} << 1) + {{ARG_W{1'b0}}, d};
    if (w_sum > {4'b0, ARG_MAX}) return ARG_MAX;
    return w_sum[ARG_W-1:0];
  endfunction

  state_t           r_state, w_state_nxt;
  logic [ARG_W-1:0] r_arg0, r_arg1, w_arg0_nxt, w_arg1_nxt;
  logic             r_idx, w_idx_nxt;      // 0: filling arg0, 1: filling arg1
  logic             r_pres0, w_pres0_nxt;  // a digit was seen for arg0
  logic             r_ovf, w_ovf_nxt;      // more than two args: rest discarded

  logic             r_cmd_valid;
  logic [2:0]       r_cmd_op;
  logic [7:0]       r_cmd_char;
  logic [ARG_W-1:0] r_cmd_arg0, r_cmd_arg1;
  logic [1:0]       r_cmd_nargs;

  logic             w_in_ready, w_in_xfer;
  logic             w_emit, w_err;
  logic [2:0]       w_op;
  logic [7:0]       w_char;
  logic [ARG_W-1:0] w_a0, w_a1;
  logic [1:0]       w_nargs, w_seen;
  logic             w_is_digit;

  // A byte offered while reset is held is never consumed.
  assign w_in_ready = !rst && (!r_cmd_valid || cmd_ready);
  assign w_in_xfer  = in_valid && w_in_ready;
  assign w_is_digit = (in_data >= 8'h30) && (in_data <= 8'h39);

  // Arguments counted so far: moving to arg1 implies two, capped at two.
  assign w_seen = r_idx ? 2'd2 : (r_pres0 ? 2'd1 : 2'd0);

  always_comb begin
    w_state_nxt = r_state;
    w_arg0_nxt  = r_arg0;
    w_arg1_nxt  = r_arg1;
    w_idx_nxt   = r_idx;
    w_pres0_nxt = r_pres0;
    w_ovf_nxt   = r_ovf;
    w_emit      = 1'b0;
    w_err       = 1'b0;
    w_op        = OP_CHAR;
    w_char      = 8'd0;
    w_a0        = '0;
    w_a1        = '0;
    w_nargs     = 2'd0;

    if (w_in_xfer) begin
      case (r_state)
        S_IDLE: begin
          if (in_data == 8'h1B) begin
            w_state_nxt = S_ESC;
          end else if (in_data == 8'h0A) begin
            w_emit = 1'b1;
            w_op   = OP_NEWLINE;
          end else if ((in_data >= 8'h20) && (in_data != 8'h7F)) begin
            w_emit = 1'b1;
            w_op   = OP_CHAR;
            w_char = in_data;
          end
        end

        S_ESC: begin
          if (in_data == 8'h5B) begin
            w_state_nxt = S_CSI;
            w_arg0_nxt  = '0;
            w_arg1_nxt  = '0;
            w_idx_nxt   = 1'b0;
            w_pres0_nxt = 1'b0;
            w_ovf_nxt   = 1'b0;
          end else if (in_data == 8'h1B) begin
            w_err = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
            w_err       = 1'b1;
          end
        end

        S_CSI: begin
          if (w_is_digit) begin
            if (!r_ovf) begin
              if (!r_idx) begin
                w_arg0_nxt  = acc_digit(r_arg0, in_data[3:0]);
                w_pres0_nxt = 1'b1;
              end else begin
                w_arg1_nxt = acc_digit(r_arg1, in_data[3:0]);
              end
            end
          end else if (in_data == 8'h3B) begin
            if (!r_idx) w_idx_nxt = 1'b1;
            else        w_ovf_nxt = 1'b1;
          end else if ((in_data >= 8'h40) && (in_data <= 8'h7E)) begin
            w_state_nxt = S_IDLE;
            case (in_data)
              8'h48: begin  // 'H'
                w_emit = 1'b1;
                if (w_seen == 2'd0) begin
                  w_op = OP_HOME;
                end else begin
                  w_op = OP_GOTO;
                  w_a0 = (r_arg0 == '0) ? ARG_ONE : r_arg0;
                  w_a1 = (r_arg1 == '0) ? ARG_ONE : r_arg1;
                end
              end
              8'h4A: begin  // 'J'
                if (r_arg0 == ARG_TWO) begin
                  w_emit = 1'b1;
                  w_op   = OP_CLEAR;
                end else begin
                  w_err = 1'b1;
                end
              end
              8'h6D: begin  // 'm'
                w_emit  = 1'b1;
                w_op    = OP_SGR;
                w_a0    = r_arg0;
                w_a1    = r_arg1;
                w_nargs = w_seen;
              end
              default: w_err = 1'b1;
            endcase
          end else if (in_data == 8'h1B) begin
            w_state_nxt = S_ESC;
            w_err       = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
            w_err       = 1'b1;
          end
        end

        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_arg0      <= '0;
      r_arg1      <= '0;
      r_idx       <= 1'b0;
      r_pres0     <= 1'b0;
      r_ovf       <= 1'b0;
      r_cmd_valid <= 1'b0;
      r_cmd_op    <= 3'd0;
      r_cmd_char  <= 8'd0;
      r_cmd_arg0  <= '0;
      r_cmd_arg1  <= '0;
      r_cmd_nargs <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_arg0  <= w_arg0_nxt;
      r_arg1  <= w_arg1_nxt;
      r_idx   <= w_idx_nxt;
      r_pres0 <= w_pres0_nxt;
      r_ovf   <= w_ovf_nxt;
      // A new command can only be produced when the slot is free or being
      // emptied this cycle, so loading it never drops a pending command.
      if (w_emit) begin
        r_cmd_valid <= 1'b1;
        r_cmd_op    <= w_op;
        r_cmd_char  <= w_char;
        r_cmd_arg0  <= w_a0;
        r_cmd_arg1  <= w_a1;
        r_cmd_nargs <= w_nargs;
      end else if (cmd_ready) begin
        r_cmd_valid <= 1'b0;
      end
    end
  end

`ifdef ANSI_DECODER_ERRCNT_EN
  logic [7:0] r_err_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_count <= 8'd0;
    end else if (w_err && (r_err_count != 8'hFF)) begin
      r_err_count <= r_err_count + 8'd1;
    end
  end

  assign err_count = r_err_count;
`else
  logic w_unused_err;
  assign w_unused_err = w_err;
  assign err_count    = 8'd0;
`endif

  assign in_ready    = w_in_ready;
  assign cmd_valid   = r_cmd_valid;
  assign cmd_op      = r_cmd_op;
  assign cmd_char    = r_cmd_char;
  assign cmd_arg0    = r_cmd_arg0;
  assign cmd_arg1    = r_cmd_arg1;
  assign cmd_nargs   = r_cmd_nargs;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ansi_decoder.sv
// Testbench for ansi_decoder: directed byte sequences, expected commands
// pushed into a queue at stimulus time, popped and compared by a monitor
// whenever a command transfer takes place.
module tb_ansi_decoder;
  localparam int ARG_W = 8;
  localparam int EW    = 3 + 8 + ARG_W + ARG_W + 2;

`ifdef ANSI_DECODER_ERRCNT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  localparam logic [2:0] OP_CHAR    = 3'd0;
  localparam logic [2:0] OP_NEWLINE = 3'd1;
  localparam logic [2:0] OP_GOTO    = 3'd2;
  localparam logic [2:0] OP_SGR     = 3'd3;
  localparam logic [2:0] OP_CLEAR   = 3'd4;
  localparam logic [2:0] OP_HOME    = 3'd5;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_ready;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [7:0]       cmd_char;
  logic [ARG_W-1:0] cmd_arg0;
  logic [ARG_W-1:0] cmd_arg1;
  logic [1:0]       cmd_nargs;
  logic [7:0]       err_count;
  logic [1:0]       dbg_state;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_got;
  logic [EW-1:0] mon_exp;
  int n_checks = 0;
  int n_pass   = 0;
  int exp_err  = 0;

  ansi_decoder #(.ARG_W(ARG_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_char   (cmd_char),
    .cmd_arg0   (cmd_arg0),
    .cmd_arg1   (cmd_arg1),
    .cmd_nargs  (cmd_nargs),
    .err_count  (err_count),
    .o_dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  function automatic logic [EW-1:0] pk(input logic [2:0] op, input logic [7:0] ch,
                                       input logic [ARG_W-1:0] a0,
                                       input logic [ARG_W-1:0] a1,
                                       input logic [1:0] n);
    return {op, ch, a0, a1, n};
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic err_ev();
    if (ERR_EN) exp_err++;
  endtask

  // ---------------- driver ----------------
  // Called at (or just after) a falling edge; returns at the falling edge
  // following the accepting rising edge.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = b;
    #1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      n_checks++;
      $display("FAIL send_timeout: in_ready stayed 0 for byte %02h, expected 1", b);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s.getc(i));
  endtask

  task automatic csi(input string body);
    send_byte(8'h1B);
    send_byte(8'h5B);
    send_str(body);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    #2;
    if (!rst && cmd_valid && cmd_ready) begin
      mon_got = {cmd_op, cmd_char, cmd_arg0, cmd_arg1, cmd_nargs};
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL cmd_unexpected: got op=%0d char=%02h a0=%0d a1=%0d n=%0d expected none",
                 cmd_op, cmd_char, cmd_arg0, cmd_arg1, cmd_nargs);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got === mon_exp) n_pass++;
        else $display("FAIL cmd: got %h expected %h (op,char,a0,a1,nargs)", mon_got, mon_exp);
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    cmd_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    check("rst_cmd_fields", 32'({cmd_op, cmd_char, cmd_arg0, cmd_arg1, cmd_nargs}), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_state", 32'(dbg_state), 32'd0);

    // GOTO with 1-cycle latency, valid for exactly one cycle
    exp_q.push_back(pk(OP_GOTO, 8'd0, 8'd12, 8'd40, 2'd0));
    csi("12;40H");
    #1;
    check("goto_valid_after_H", 32'(cmd_valid), 32'd1);
    @(negedge clk);
    #1;
    check("goto_valid_one_cycle", 32'(cmd_valid), 32'd0);

    // SGR with two args, then one arg
    exp_q.push_back(pk(OP_SGR, 8'd0, 8'd1, 8'd33, 2'd2));
    csi("1;33m");
    exp_q.push_back(pk(OP_SGR, 8'd0, 8'd0, 8'd0, 2'd1));
    csi("0m");

    // CLEAR, HOME, CHAR, NEWLINE
    exp_q.push_back(pk(OP_CLEAR, 8'd0, 8'd0, 8'd0, 2'd0));
    csi("2J");
    exp_q.push_back(pk(OP_HOME, 8'd0, 8'd0, 8'd0, 2'd0));
    csi("H");
    exp_q.push_back(pk(OP_CHAR, 8'h41, 8'd0, 8'd0, 2'd0));
    send_byte(8'h41);
    exp_q.push_back(pk(OP_NEWLINE, 8'd0, 8'd0, 8'd0, 2'd0));
    send_byte(8'h0A);
    check("err_after_clear_home", 32'(err_count), 32'd0);

    // saturation and unknown final
    exp_q.push_back(pk(OP_GOTO, 8'd0, 8'd255, 8'd3, 2'd0));
    csi("999;3H");
    csi("5X");
    err_ev();
    check("err_after_5X", 32'(err_count), 32'(exp_err));

    // absent / zero GOTO arguments default to 1
    exp_q.push_back(pk(OP_GOTO, 8'd0, 8'd1, 8'd1, 2'd0));
    csi(";H");
    exp_q.push_back(pk(OP_GOTO, 8'd0, 8'd1, 8'd1, 2'd0));
    csi("0;0H");
    exp_q.push_back(pk(OP_GOTO, 8'd0, 8'd7, 8'd1, 2'd0));
    csi("7H");

    // extra SGR arguments are discarded without error
    exp_q.push_back(pk(OP_SGR, 8'd0, 8'd1, 8'd2, 2'd2));
    csi("1;2;3m");
    check("err_after_overflow", 32'(err_count), 32'(exp_err));

    // error paths
    csi("3J");
    err_ev();
    send_byte(8'h1B);
    send_byte(8'h1B);
    err_ev();
    exp_q.push_back(pk(OP_SGR, 8'd0, 8'd0, 8'd0, 2'd0));
    send_str("[m");
    send_byte(8'h1B);
    send_byte(8'h78);   // ESC x: dropped, 'x' not printed
    err_ev();
    csi("5");
    send_byte(8'h07);   // abort to IDLE
    err_ev();
    csi("4");
    send_byte(8'h1B);   // abort to ESC
    err_ev();
    exp_q.push_back(pk(OP_SGR, 8'd0, 8'd0, 8'd0, 2'd0));
    send_str("[m");
    check("err_after_error_paths", 32'(err_count), 32'(exp_err));
    check("state_idle_after_m", 32'(dbg_state), 32'd0);

    // ignored control bytes and a UTF-8 byte
    send_byte(8'h7F);
    send_byte(8'h05);
    exp_q.push_back(pk(OP_CHAR, 8'hC3, 8'd0, 8'd0, 2'd0));
    send_byte(8'hC3);

    // back-pressure: command held 3 cycles
    csi("3;4");
    cmd_ready = 1'b0;
    exp_q.push_back(pk(OP_GOTO, 8'd0, 8'd3, 8'd4, 2'd0));
    send_byte(8'h48);
    for (int c = 0; c < 3; c++) begin
      #1;
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_cmd_valid", 32'(cmd_valid), 32'd1);
      check("stall_cmd_fields", 32'({cmd_op, cmd_char, cmd_arg0, cmd_arg1, cmd_nargs}),
            32'(pk(OP_GOTO, 8'd0, 8'd3, 8'd4, 2'd0)));
      @(negedge clk);
    end
    cmd_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h5A;
    #1;
    check("release_in_ready", 32'(in_ready), 32'd1);
    exp_q.push_back(pk(OP_CHAR, 8'h5A, 8'd0, 8'd0, 2'd0));
    send_byte(8'h5A);

    // reset in the middle of a sequence
    csi("12");
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h51;
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    exp_err  = 0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    check("post_rst_state", 32'(dbg_state), 32'd0);
    check("post_rst_err", 32'(err_count), 32'd0);
    exp_q.push_back(pk(OP_HOME, 8'd0, 8'd0, 8'd0, 2'd0));
    csi("H");
    check("err_after_rst_home", 32'(err_count), 32'd0);

    // drain
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
